tmds_serializer: RTL and testbench
==================================

Name: tmds_serializer

Overview:
- Parametrised, single-clock TMDS gearbox for the DVI path. Runs entirely in the TMDS bit-clock domain.
- Accepts encoded 10-bit symbols for NUM_CH lanes through a valid/ready handshake, buffers one word, and shifts out OUT_BITS bits per lane per cycle for direct connection to ODDRX1F/ODDRX2F gearing.
- Generates the TMDS clock-lane pattern phase-locked to the data words.
- Inserts a control symbol and counts the event on underflow.

Parameters:
- NUM_CH, 3: number of data lanes.
- WORD_W, 10: symbol width in bits.
- OUT_BITS, 1: bits per lane emitted per cycle. Legal values are 1, 2 or 5; WORD_W mod OUT_BITS must be 0, otherwise elaboration fails.
- LSB_FIRST, 1: 1 = bit 0 is transmitted first (DVI order); 0 = MSB first.
- IDLE_SYM, 10'b1101010100: symbol loaded on underflow or when disabled (control token C1:C0 = 00).

Ports:
- clk_tmds, input, 1: bit clock divided by OUT_BITS. All logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: 1 = consume words; 0 = transmit IDLE_SYM without consuming.
- word_in, input, NUM_CH*WORD_W: lane k occupies bits [k*WORD_W +: WORD_W].
- word_valid, input, 1: word_in is valid.
- word_ready, output, 1: block accepts word_in this cycle.
- ser_out, output, NUM_CH*OUT_BITS: lane k occupies bits [k*OUT_BITS +: OUT_BITS]. Bit 0 of each group is transmitted first.
- clk_ser_out, output, OUT_BITS: clock-lane bits, same ordering as ser_out.
- word_strobe, output, 1: high on the cycle a new word enters the shifters.
- underflow, output, 1: one-cycle pulse when IDLE_SYM is loaded because data was missing.
- underflow_count, output, 16: saturating count of underflow pulses.

Behaviour:
- SLOTS = WORD_W/OUT_BITS. slot counter runs 0..SLOTS-1, wraps to 0, and free-runs after reset.
- load = (slot == SLOTS-1). On load, the shifters take the next word. Otherwise they shift OUT_BITS positions toward the output end.
- Holding register (1 entry, hold_full flag):
  - word_ready = !hold_full || (load && enable).
  - A transfer occurs when word_valid && word_ready.
- Load source priority when load=1:
  - enable=0: load IDLE_SYM. The hold register is untouched; no underflow.
  - enable=1, hold_full: load the hold contents. A concurrent transfer refills the hold, so hold_full stays 1.
  - enable=1, hold empty, transfer this cycle: bypass word_in directly into the shifters. hold_full stays 0.
  - enable=1, hold empty, no transfer: load IDLE_SYM, pulse underflow, and increment underflow_count. The count saturates at 16'hFFFF.
- Transfer when load=0 writes the hold register and sets hold_full.
- Latency:
  - Bypassed word: first bits appear on ser_out the cycle after load.
  - Held word: waits for the next load.
- Clock lane: a separate shifter loads 10'b0000011111 (LSB_FIRST order) on every load, independent of enable and underflow.
- LSB_FIRST=0: each symbol is bit-reversed at load time. The shift direction is unchanged.
- Outputs are registered straight from the shifter LSBs. There is no combinational path from word_in to ser_out.
- word_strobe is registered and equals the previous cycle's load.
- Reset values:
  - slot=0, hold_full=0, underflow=0, underflow_count=0, word_strobe=0.
  - All data shifters = IDLE_SYM; clock shifter = pattern.
  - ser_out and clk_ser_out equal the low OUT_BITS of those values.
  - word_ready=1.
- Reset mid-word: the partial symbol is abandoned and the hold contents are discarded. The first post-reset load occurs SLOTS-1 cycles after rst_n deasserts.
- enable toggling takes effect only at a load boundary. A symbol in flight is never truncated.

Decomposition:
- Shared package tmds_pkg:
  - TMDS_WORD_W.
  - The four control tokens (CTRL_00..CTRL_11).
  - TMDS_CLK_PATTERN.
  - A bit-reverse function.
  - The tmds_encoder reuses the control tokens.
- Sub-module tmds_lane_shifter:
  - Parameters WORD_W and OUT_BITS; inputs load and load_word.
  - Instantiated NUM_CH+1 times: the data lanes plus the clock lane.

Test Plan:
1. OUT_BITS=1, NUM_CH=3: stream words {R=10'h155, G=10'h2AA, B=10'h0F0} continuously. Lane 0 serial output must be 1,0,1,0,1,0,1,0,1,0 LSB-first, with no underflow and underflow_count=0.
2. OUT_BITS=2: clk_ser_out pairs over one word must be 2'b11,11,01? — check against pattern 0000011111 split as {b1,b0}: 11,11,01? Expected sequence is 2'b11, 2'b11, 2'b01, 2'b00, 2'b00. word_strobe must pulse every 5 cycles.
3. Hold word_valid low for one word period with enable=1. underflow must pulse once, ser_out must carry IDLE_SYM (1101010100), and underflow_count must equal 1. Force 65540 underflows: underflow_count must hold at 16'hFFFF.
4. Backpressure: keep word_valid high. Exactly one word is accepted per SLOTS cycles after the hold fills, and word_ready is low on the other cycles. No word is dropped or duplicated, checked with an incrementing pattern 0..99.
5. Deassert enable mid-word: the current symbol completes, then IDLE_SYM is sent with no underflow pulse. The held word is sent first after enable returns.
6. Assert rst_n low in slot 4: outputs return to reset values asynchronously and word_ready=1. The first word_strobe occurs SLOTS cycles after release.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS constants: symbol width, control tokens, clock-lane pattern
// and a bit-order helper used by the serializer and the encoder.
package tmds_pkg;

    localparam int TMDS_WORD_W = 10;

    // Control tokens indexed by {C1,C0}
    localparam logic [TMDS_WORD_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_WORD_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_WORD_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_WORD_W-1:0] CTRL_11 = 10'b1010101011;

    // Five ones then five zeros on the wire when sent bit 0 first
    localparam logic [TMDS_WORD_W-1:0] TMDS_CLK_PATTERN = 10'b0000011111;

    function automatic logic [TMDS_WORD_W-1:0] bit_reverse(input logic [TMDS_WORD_W-1:0] w);
        logic [TMDS_WORD_W-1:0] r;
        for (int i = 0; i < TMDS_WORD_W; i++) begin
            r[i] = w[TMDS_WORD_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/tmds_lane_shifter.sv
// One output lane: parallel-load shift register emitting OUT_BITS per cycle
// from its low end. The output is taken straight from register bits.
module tmds_lane_shifter
    import tmds_pkg::*;
#(
    parameter int                WORD_W     = TMDS_WORD_W,
    parameter int                OUT_BITS   = 1,
    parameter logic [WORD_W-1:0] RESET_WORD = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [WORD_W-1:0]   load_word,
    output logic [OUT_BITS-1:0] bits
);

    logic [WORD_W-1:0] sreg;

    // Take a new symbol on load, otherwise move the next group to the low end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= RESET_WORD;
        end else if (load) begin
            sreg <= load_word;
        end else begin
            sreg <= sreg >> OUT_BITS;
        end
    end

    assign bits = sreg[OUT_BITS-1:0];

endmodule

// File: rtl/tmds_serializer.sv
// TMDS gearbox: one-word holding register in front of NUM_CH data shifters
// plus a clock-lane shifter, all reloaded together at the end of each word.
// Missing data at a load boundary is replaced by IDLE_SYM and counted.
module tmds_serializer
    import tmds_pkg::*;
#(
    parameter int                NUM_CH    = 3,
    parameter int                WORD_W    = TMDS_WORD_W,
    parameter int                OUT_BITS  = 1,
    parameter bit                LSB_FIRST = 1'b1,
    parameter logic [WORD_W-1:0] IDLE_SYM  = CTRL_00
) (
    input  logic                         clk_tmds,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [NUM_CH*WORD_W-1:0]     word_in,
    input  logic                         word_valid,
    output logic                         word_ready,
    output logic [NUM_CH*OUT_BITS-1:0]   ser_out,
    output logic [OUT_BITS-1:0]          clk_ser_out,
    output logic                         word_strobe,
    output logic                         underflow,
    output logic [15:0]                  underflow_count
);

    localparam int SLOTS  = WORD_W / OUT_BITS;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    // Low half ones, high half zeros: the clock pattern for any even width
    localparam logic [WORD_W-1:0] CLK_WORD = {WORD_W{1'b1}} >> (WORD_W - WORD_W / 2);

    if (!(OUT_BITS == 1 || OUT_BITS == 2 || OUT_BITS == 5) || (WORD_W % OUT_BITS) != 0) begin : g_bad_gearing
        $error("tmds_serializer: OUT_BITS must be 1, 2 or 5 and divide WORD_W");
    end

    // MSB-first lanes are realised by reversing the symbol once at load
    function automatic logic [WORD_W-1:0] orient(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        for (int i = 0; i < WORD_W; i++) begin
            r[i] = LSB_FIRST ? w[i] : w[WORD_W-1-i];
        end
        return r;
    endfunction

    localparam logic [WORD_W-1:0] IDLE_TX = orient(IDLE_SYM);

    logic [SLOT_W-1:0]        slot;
    logic                     load;
    logic                     transfer;
    logic                     hold_full;
    logic [NUM_CH*WORD_W-1:0] hold_word;
    logic [NUM_CH*WORD_W-1:0] load_src;
    logic                     starve;

    assign load       = (slot == LAST_SLOT);
    assign word_ready = !hold_full || (load && enable);
    assign transfer   = word_valid && word_ready;

    // Free-running position within the current symbol
    always_ff @(posedge clk_tmds or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (load) begin
            slot <= '0;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    // Pick what the shifters take at the next load: hold, bypass or idle
    always_comb begin
        load_src = {NUM_CH{IDLE_SYM}};
        starve   = 1'b0;
        if (enable) begin
            if (hold_full) begin
                load_src = hold_word;
            end else if (transfer) begin
                load_src = word_in;
            end else begin
                starve = 1'b1;
            end
        end
    end

    // Hold occupancy, strobe and underflow bookkeeping
    always_ff @(posedge clk_tmds or negedge rst_n) begin
        if (!rst_n) begin
            hold_full       <= 1'b0;
            word_strobe     <= 1'b0;
            underflow       <= 1'b0;
            underflow_count <= '0;
        end else begin
            word_strobe <= load;
            underflow   <= load && starve;
            if (load && starve && underflow_count != 16'hFFFF) begin
                underflow_count <= underflow_count + 16'd1;
            end
            if (transfer) begin
                // Only a bypass (load, enabled, hold empty) leaves the hold empty
                hold_full <= hold_full || !load || !enable;
            end else if (load && enable) begin
                hold_full <= 1'b0;
            end
        end
    end

    // Hold data needs no reset: it is qualified by hold_full
    always_ff @(posedge clk_tmds) begin
        if (transfer) begin
            hold_word <= word_in;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic [WORD_W-1:0]   lane_word;
        logic [OUT_BITS-1:0] lane_bits;

        assign lane_word = orient(load_src[k*WORD_W +: WORD_W]);

        tmds_lane_shifter #(
            .WORD_W     (WORD_W),
            .OUT_BITS   (OUT_BITS),
            .RESET_WORD (IDLE_TX)
        ) u_shift (
            .clk       (clk_tmds),
            .rst_n     (rst_n),
            .load      (load),
            .load_word (lane_word),
            .bits      (lane_bits)
        );

        assign ser_out[k*OUT_BITS +: OUT_BITS] = lane_bits;
    end

    tmds_lane_shifter #(
        .WORD_W     (WORD_W),
        .OUT_BITS   (OUT_BITS),
        .RESET_WORD (CLK_WORD)
    ) u_clk_shift (
        .clk       (clk_tmds),
        .rst_n     (rst_n),
        .load      (load),
        .load_word (CLK_WORD),
        .bits      (clk_ser_out)
    );

endmodule

// File: tb/tb_tmds_serializer.sv
// Self-checking bench: a queue-based word-level model predicts every output
// of a 1-bit-per-cycle instance each cycle; a second 2-bit instance checks the
// clock-lane pairing and strobe period against literal tables.
module tb_tmds_serializer;

    localparam int SLOTS = 10;
    localparam logic [9:0] IDLE = 10'b1101010100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        enable;
    logic        word_valid;
    logic [29:0] word_in;
    logic        word_ready;
    logic [2:0]  ser_out;
    logic [0:0]  clk_ser_out;
    logic        word_strobe;
    logic        underflow;
    logic [15:0] underflow_count;

    tmds_serializer #(
        .NUM_CH(3), .WORD_W(10), .OUT_BITS(1), .LSB_FIRST(1'b1), .IDLE_SYM(10'b1101010100)
    ) dut (
        .clk_tmds(clk), .rst_n(rst_n), .enable(enable), .word_in(word_in),
        .word_valid(word_valid), .word_ready(word_ready), .ser_out(ser_out),
        .clk_ser_out(clk_ser_out), .word_strobe(word_strobe), .underflow(underflow),
        .underflow_count(underflow_count)
    );

    logic        rst2_n;
    logic        enable2 = 1'b1;
    logic        valid2 = 1'b1;
    logic [29:0] word2 = {10'h0F0, 10'h2AA, 10'h155};
    logic        ready2;
    logic [5:0]  ser2;
    logic [1:0]  clk2;
    logic        strobe2;
    logic        uf2;
    logic [15:0] cnt2;

    tmds_serializer #(
        .NUM_CH(3), .WORD_W(10), .OUT_BITS(2), .LSB_FIRST(1'b1), .IDLE_SYM(10'b1101010100)
    ) dut2 (
        .clk_tmds(clk), .rst_n(rst2_n), .enable(enable2), .word_in(word2),
        .word_valid(valid2), .word_ready(ready2), .ser_out(ser2),
        .clk_ser_out(clk2), .word_strobe(strobe2), .underflow(uf2),
        .underflow_count(cnt2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Behavioural model state
    int          m_slot;
    logic [29:0] m_q[$];
    logic [29:0] m_cur;
    logic        m_strobe, m_uf;
    logic [15:0] m_cnt;
    logic [9:0]  clk_pat = 10'b0000011111;

    // Lane-0 words reassembled from the serial output
    logic [9:0]  rx_word[$];
    logic        rx_uf[$];
    logic [9:0]  bitbuf;
    logic        buf_uf;
    int          uf_seen;
    logic        last_xfer;

    task automatic model_reset();
        m_slot = 0;
        m_q.delete();
        m_cur = {3{IDLE}};
        m_strobe = 1'b0;
        m_uf = 1'b0;
        m_cnt = 16'd0;
    endtask

    function automatic logic exp_ready();
        return (m_q.size() == 0) || (m_slot == SLOTS - 1 && enable);
    endfunction

    task automatic model_edge();
        logic ld, xfer;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ld   = (m_slot == SLOTS - 1);
        xfer = word_valid && exp_ready();
        m_uf = 1'b0;
        if (ld && enable) begin
            if (xfer) m_q.push_back(word_in);
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
            end else begin
                m_cur = {3{IDLE}};
                m_uf  = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end else begin
            if (ld) m_cur = {3{IDLE}};
            if (xfer) m_q.push_back(word_in);
        end
        if (m_q.size() > 1) timeout("model_queue_overflow");
        m_strobe = ld;
        m_slot = (m_slot + 1) % SLOTS;
    endtask

    task automatic compare_outputs();
        logic [2:0] e;
        e = {m_cur[20 + m_slot], m_cur[10 + m_slot], m_cur[m_slot]};
        check("ser_out", ser_out, e);
        check("clk_ser_out", clk_ser_out, clk_pat[m_slot]);
        check("word_strobe", word_strobe, m_strobe);
        check("underflow", underflow, m_uf);
        check("underflow_count", underflow_count, m_cnt);
        check("word_ready", word_ready, exp_ready());
        last_xfer = word_valid && word_ready;
        if (underflow === 1'b1) uf_seen++;
        if (m_slot == 0) buf_uf = underflow;
        bitbuf[m_slot] = ser_out[0];
        if (m_slot == SLOTS - 1) begin
            rx_word.push_back(bitbuf);
            rx_uf.push_back(buf_uf);
        end
    endtask

    // Called at a falling edge with inputs already driven
    task automatic cycle();
        #1;
        compare_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Clock-lane pairing and strobe period on the 2-bit instance
    logic done2 = 1'b0;
    initial begin
        int clk_pairs[5] = '{3, 3, 1, 0, 0};
        logic [9:0] w0, w1, w2;
        int c, s;
        rst2_n = 1'b0;
        repeat (3) @(negedge clk);
        rst2_n = 1'b1;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            #1;
            s = c % 5;
            w0 = (c >= 5) ? 10'h155 : IDLE;
            w1 = (c >= 5) ? 10'h2AA : IDLE;
            w2 = (c >= 5) ? 10'h0F0 : IDLE;
            check("ob2_clk_pair", clk2, clk_pairs[s]);
            check("ob2_ser_out", ser2, {w2[2*s +: 2], w1[2*s +: 2], w0[2*s +: 2]});
            check("ob2_word_strobe", strobe2, (c >= 5) && (s == 0));
            check("ob2_underflow", uf2, 1'b0);
        end
        done2 = 1'b1;
    end

    initial begin
        int mark, cnt, bad, n, wait_n;
        logic [9:0] seq[$];
        rst_n = 1'b0;
        enable = 1'b1;
        word_valid = 1'b0;
        word_in = '0;
        uf_seen = 0;
        bitbuf = '0;
        buf_uf = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_ser_out", ser_out, 3'b000);
        check("reset_clk_ser_out", clk_ser_out, 1'b1);
        check("reset_word_ready", word_ready, 1'b1);
        check("reset_word_strobe", word_strobe, 1'b0);
        check("reset_underflow", underflow, 1'b0);
        check("reset_underflow_count", underflow_count, 16'd0);
        rst_n = 1'b1;

        // Continuous RGB stream
        word_in = {10'h0F0, 10'h2AA, 10'h155};
        word_valid = 1'b1;
        repeat (40) cycle();
        check("rgb_lane0_word", rx_word[rx_word.size() - 1], 10'h155);
        check("rgb_underflow_count", underflow_count, 16'd0);

        // One missing word period
        wait_n = 0;
        while (m_slot != 0) begin
            cycle();
            if (++wait_n > 20) begin timeout("align_underflow"); break; end
        end
        mark = rx_word.size();
        word_valid = 1'b0;
        repeat (20) cycle();
        word_valid = 1'b1;
        repeat (30) cycle();
        cnt = 0;
        for (int i = mark; i < rx_word.size(); i++) begin
            if (rx_uf[i]) begin
                cnt++;
                check("underflow_word_is_idle", rx_word[i], IDLE);
            end
        end
        check("underflow_pulses", cnt, 1);
        check("underflow_count_one", underflow_count, 16'd1);

        // Disable mid-word with a word parked in the hold register
        word_valid = 1'b0;
        wait_n = 0;
        while (!(m_q.size() == 0 && m_slot == 4)) begin
            cycle();
            if (++wait_n > 40) begin timeout("align_disable"); break; end
        end
        enable = 1'b0;
        word_valid = 1'b1;
        word_in = {3{10'h1C3}};
        cycle();
        word_in = {3{10'h2E1}};
        mark = rx_word.size();
        uf_seen = 0;
        repeat (25) cycle();
        check("disable_no_underflow", uf_seen, 0);
        enable = 1'b1;
        repeat (40) cycle();
        seq.delete();
        for (int i = mark + 1; i < rx_word.size(); i++) begin
            if (rx_word[i] != IDLE) seq.push_back(rx_word[i]);
        end
        check("resume_first_is_held", (seq.size() > 0) ? seq[0] : 10'h3FF, 10'h1C3);
        check("resume_second", (seq.size() > 1) ? seq[1] : 10'h3FF, 10'h2E1);

        // Backpressure with an incrementing pattern
        word_valid = 1'b0;
        wait_n = 0;
        while (m_q.size() != 0) begin
            cycle();
            if (++wait_n > 30) begin timeout("drain_hold"); break; end
        end
        repeat (11) cycle();
        mark = rx_word.size();
        n = 0;
        wait_n = 0;
        while (n < 100) begin
            word_in = {3{n[9:0]}};
            word_valid = 1'b1;
            cycle();
            if (last_xfer) n++;
            if (++wait_n > 1300) begin timeout("backpressure_stream"); break; end
        end
        word_valid = 1'b0;
        repeat (40) cycle();
        seq.delete();
        for (int i = mark; i < rx_word.size(); i++) begin
            if (rx_word[i] != IDLE) seq.push_back(rx_word[i]);
        end
        bad = -1;
        for (int j = seq.size() - 1; j >= 0; j--) begin
            if (seq[j] != 10'(j)) bad = j;
        end
        check("bp_word_count", seq.size(), 100);
        check("bp_first_bad_index", bad, -1);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            word_valid = ($urandom_range(0, 3) != 0);
            word_in = 30'($urandom);
            cycle();
        end

        // Asynchronous reset in slot 4
        enable = 1'b1;
        word_valid = 1'b1;
        word_in = 30'($urandom);
        wait_n = 0;
        while (m_slot != 4) begin
            cycle();
            if (++wait_n > 12) begin timeout("align_reset"); break; end
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_ser_out", ser_out, 3'b000);
        check("async_clk_ser_out", clk_ser_out, 1'b1);
        check("async_word_ready", word_ready, 1'b1);
        check("async_underflow_count", underflow_count, 16'd0);
        check("async_word_strobe", word_strobe, 1'b0);
        repeat (2) cycle();
        rst_n = 1'b1;
        n = 0;
        while (1) begin
            cycle();
            n++;
            if (word_strobe === 1'b1) break;
            if (n > 20) begin timeout("first_strobe"); break; end
        end
        check("first_strobe_latency", n, SLOTS);

        // Saturation of the underflow counter
        enable = 1'b0;
        word_valid = 1'b0;
        force dut.underflow_count = 16'hFFFC;
        m_cnt = 16'hFFFC;
        cycle();
        release dut.underflow_count;
        enable = 1'b1;
        repeat (80) cycle();
        check("underflow_count_saturated", underflow_count, 16'hFFFF);

        wait_n = 0;
        while (!done2) begin
            @(negedge clk);
            if (++wait_n > 100) begin timeout("ob2_done"); break; end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
